vram_dump: RTL



---
 rtl/vdp_pkg.sv | 35 +++
 rtl/vram_dump_if.sv | 34 +++
 rtl/vram_dump.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// ============================================================================
// vdp_pkg : constants shared by the VDP VRAM blocks.
// Also holds the state encoding of the VRAM dump engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_SIZE   = 16384;

  localparam logic [2:0] C_S_IDLE    = 3'd0;
  localparam logic [2:0] C_S_READ    = 3'd1;
  localparam logic [2:0] C_S_LOAD    = 3'd2;
  localparam logic [2:0] C_S_SEND    = 3'd3;
  localparam logic [2:0] C_S_WAIT_TX = 3'd4;
  localparam logic [2:0] C_S_NEXT    = 3'd5;
  localparam logic [2:0] C_S_DONE    = 3'd6;
  localparam logic [2:0] C_S_CSUM    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = C_S_IDLE,
    S_READ    = C_S_READ,
    S_LOAD    = C_S_LOAD,
    S_SEND    = C_S_SEND,
    S_WAIT_TX = C_S_WAIT_TX,
    S_NEXT    = C_S_NEXT,
    S_DONE    = C_S_DONE,
    S_CSUM    = C_S_CSUM
  } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/vram_dump_if.sv
// ============================================================================
// vram_dump_if : command, VRAM read port and UART tx signals of vram_dump.
// master = dump engine, slave = surrounding system. Revision: 1.0
// ============================================================================
`default_nettype none

interface vram_dump_if #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_do;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  bytes_left;

  modport master (
    input  start, base_addr, length, vram_do, tx_done,
    output vram_addr, tx_data, tx_wr, busy, done, bytes_left
  );

  modport slave (
    output start, base_addr, length, vram_do, tx_done,
    input  vram_addr, tx_data, tx_wr, busy, done, bytes_left
  );
endinterface

`default_nettype wire

// File: rtl/vram_dump.sv
// ============================================================================
// vram_dump : streams a VRAM region out over the UART, one byte per frame.
// Optional trailing checksum frame with VRAM_DUMP_CHECKSUM_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module vram_dump
  import vdp_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int LEN_W  = 15,
  parameter int RD_LAT = 1
) (
  input  wire logic    vga_clk,
  input  wire logic    rst,
  vram_dump_if.master  bus
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [1:0]        lat_q, lat_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef VRAM_DUMP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_phase_q, csum_phase_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    lat_d     = lat_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef VRAM_DUMP_CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          left_d = bus.length;
          lat_d  = '0;
          busy_d = 1'b1;
`ifdef VRAM_DUMP_CHECKSUM_EN
          csum_d       = '0;
          csum_phase_d = 1'b0;
          state_d      = (bus.length == '0) ? S_CSUM : S_READ;
`else
          if (bus.length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_READ;
          end
`endif
        end
      end
      S_READ: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = S_LOAD;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_LOAD: begin
        tx_data_d = bus.vram_do;
        tx_wr_d   = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
`ifdef VRAM_DUMP_CHECKSUM_EN
        csum_d = csum_q + tx_data_q;
`endif
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        // tx_done is only honoured here so stale frame-complete pulses are dropped
        if (bus.tx_done) begin
`ifdef VRAM_DUMP_CHECKSUM_EN
          if (csum_phase_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_NEXT;
          end
`else
          state_d = S_NEXT;
`endif
        end
      end
      S_NEXT: begin
        addr_d = addr_q + ADDR_W'(1);
        left_d = left_q - LEN_W'(1);
        if (left_q == LEN_W'(1)) begin
`ifdef VRAM_DUMP_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`endif
        end else begin
          state_d = S_READ;
        end
      end
`ifdef VRAM_DUMP_CHECKSUM_EN
      S_CSUM: begin
        tx_data_d    = csum_q;
        tx_wr_d      = 1'b1;
        csum_phase_d = 1'b1;
        state_d      = S_SEND;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      lat_q     <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef VRAM_DUMP_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      lat_q     <= lat_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef VRAM_DUMP_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  assign bus.vram_addr  = addr_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_wr      = tx_wr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bytes_left = left_q;

endmodule

`default_nettype wire
